uart_tx: RTL
============

// Module: uart_tx
// PURPOSE
//  Serial UART transmitter, 8N1 format, LSB first: counterpart of the UART receiver.
//  Accepts a byte on a single-cycle start strobe and shifts it out on serialTX.
//  Bit timing comes from a free-counting clock divider (CLKCOUNTER cycles per bit).
//  Sits between the user/control logic and the TX pin of the board.
// PARAMETERS
//  CLKCOUNTER    10_417  clk cycles per bit (100 MHz / 9600 baud); must be >= 2
//  NBITS_COUNTER 14      width of bit-period counter; 2**NBITS_COUNTER > CLKCOUNTER
// PORTS
//  clk       input  1  system clock, all logic on rising edge
//  rst       input  1  asynchronous reset, active low
//  start     input  1  request to send dataTX; sampled only in IDLE
//  dataTX    input  8  byte to send; captured on the cycle start is accepted
//  serialTX  output 1  UART line, idle high; driven from a flop (glitch-free)
//  busy      output 1  high from the cycle after acceptance until the stop bit ends
//  done      output 1  one-cycle pulse after the stop bit completes
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, serialTX=1, busy=0, done=0, counter=0,
//   shift reg=0, bit index=0. Reset mid-frame aborts the frame; line returns high at once.
//  States: IDLE -> TX_START -> TX_DATA -> TX_STOP -> DONE -> IDLE.
//  IDLE: serialTX=1, busy=0, done=0. If start=1 at edge: latch dataTX, counter=0,
//   bit index=0, go TX_START. If start=0, stay in IDLE.
//  TX_START: serialTX=0 for exactly CLKCOUNTER cycles (counter 0..CLKCOUNTER-1).
//   At counter==CLKCOUNTER-1: counter=0, go TX_DATA.
//  TX_DATA: serialTX=shift[idx] for exactly CLKCOUNTER cycles per bit, idx 0..7 (LSB first).
//   At end of bit: if idx<7 then idx+1 and stay; else idx=0, go TX_STOP.
//  TX_STOP: serialTX=1 for exactly CLKCOUNTER cycles, then go DONE.
//  DONE: one cycle; done=1, busy=0, serialTX=1; unconditionally go IDLE.
//  busy=1 in TX_START/TX_DATA/TX_STOP, else 0. done=1 only in DONE.
//  Frame timing: first low cycle on serialTX is the cycle after start is accepted;
//   start+8 data+stop = 10*CLKCOUNTER cycles, then done pulse.
//  start while busy or in DONE: ignored (no queueing); dataTX changes mid-frame have no effect.
//  start held high continuously: back-to-back frames, with DONE cycle plus one IDLE cycle
//   (2 cycles of high line) between the stop bit and the next start bit.
//  Counter never exceeds CLKCOUNTER-1; no wrap. Illegal state codes -> IDLE, serialTX=1.
// TESTING (bench uses CLKCOUNTER=16, NBITS_COUNTER=5)
//  Reset: hold rst=0 -> serialTX=1, busy=0, done=0; release, no start -> line stays high.
//  Send 8'hA5: pulse start 1 cycle -> line 0 for 16 cycles, then bits 1,0,1,0,0,1,0,1
//   at 16 cycles each, stop 1 for 16 cycles; done=1 exactly at cycle 161 after the accepting edge.
//  Edge bytes 8'h00 and 8'hFF -> 8 low / 8 high data bits; stop bit always high.
//  start pulsed mid-frame with dataTX=8'h3C during 8'h55 frame -> only 8'h55 sent, busy steady.
//  start held high with 8'h81 -> repeated frames, exactly 2 high cycles between stop and start.
//  rst asserted during TX_DATA bit 3 -> serialTX=1 and busy=0 immediately; next start sends a clean frame.
//  Loopback into the UART receiver for 256 random bytes -> every received byte matches.

Source files
------------

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, fixed clock-divider bit timing.
// All outputs come straight from flops, so serialTX is glitch-free.
module uart_tx #(
  parameter int CLKCOUNTER    = 10_417,
  parameter int NBITS_COUNTER = 14
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] dataTX,
  output logic       serialTX,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    TX_START = 3'd1,
    TX_DATA  = 3'd2,
    TX_STOP  = 3'd3,
    DONE     = 3'd4
  } state_t;

  localparam logic [NBITS_COUNTER-1:0] LAST =
    NBITS_COUNTER'(CLKCOUNTER - 1);

  state_t                   state, state_n;
  logic [NBITS_COUNTER-1:0] cnt, cnt_n;
  logic [7:0]               shift, shift_n;
  logic [2:0]               idx, idx_n;
  logic                     line_n, busy_n, done_n;
  logic                     bit_end;

  assign bit_end = (cnt == LAST);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    shift_n = shift;
    idx_n   = idx;
    case (state)
      IDLE: begin
        if (start) begin
          shift_n = dataTX;
          cnt_n   = '0;
          idx_n   = '0;
          state_n = TX_START;
        end
      end
      TX_START: begin
        if (bit_end) begin
          cnt_n   = '0;
          state_n = TX_DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          cnt_n = '0;
          if (idx == 3'd7) begin
            idx_n   = '0;
            state_n = TX_STOP;
          end else begin
            idx_n = idx + 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      TX_STOP: begin
        if (bit_end) begin
          cnt_n   = '0;
          state_n = DONE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        idx_n   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with it.
  always_comb begin
    line_n = 1'b1;
    busy_n = 1'b0;
    done_n = 1'b0;
    case (state_n)
      TX_START: begin
        line_n = 1'b0;
        busy_n = 1'b1;
      end
      TX_DATA: begin
        line_n = shift_n[idx_n];
        busy_n = 1'b1;
      end
      TX_STOP: begin
        busy_n = 1'b1;
      end
      DONE: begin
        done_n = 1'b1;
      end
      default: begin
        line_n = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      shift    <= '0;
      idx      <= '0;
      serialTX <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      shift    <= shift_n;
      idx      <= idx_n;
      serialTX <= line_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

endmodule
